// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
//
// Shares one serial 8-bit pattern-detect window between NREQ byte-stream
// requesters. A round-robin arbiter grants one requester per frame. The
// granted requester's bytes are fetched over a valid/ready handshake and
// shifted MSB-first, one bit per clock, into the window. From the 8th bit of
// the frame onward the window is compared against a 4-entry programmable
// pattern table. One result (requester id, last match code, saturating hit
// count) is emitted per frame.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   cfg_we     pattern-table write strobe
//   cfg_idx    table entry to write
//   cfg_pat    pattern value to write
//   req        per-requester frame request (level)
//   gnt        one-hot grant, held for the whole frame
//   byte_rdy   ready for the next byte from the granted requester
//   byte_vld   granted requester's byte is valid
//   byte_in    byte data
//   byte_last  marks byte_in as the final byte of the frame
//   res_valid  one-cycle result strobe
//   res_id     requester index of the result
//   res_code   last match code: 1..4 = table entry 0..3, 0 = none
//   res_hits   matches in the frame, saturating at 255

module seq_detect_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_idx,
    input  logic [7:0]      cfg_pat,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            byte_rdy,
    input  logic            byte_vld,
    input  logic [7:0]      byte_in,
    input  logic            byte_last,
    output logic            res_valid,
    output logic [IDW-1:0]  res_id,
    output logic [3:0]      res_code,
    output logic [7:0]      res_hits
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [7:0]      pat_tbl [4];
    logic [IDW-1:0]  rr_ptr;
    logic [7:0]      window;
    logic [3:0]      bit_cnt;
    logic [7:0]      byte_q;
    logic            last_q;
    logic [2:0]      shift_k;
    logic [3:0]      code_acc;
    logic [7:0]      hit_cnt;

    // Arbiter result
    logic            arb_found;
    logic [IDW-1:0]  arb_idx;
    int              cand;

    // Shift / compare datapath
    logic [7:0]      new_window;
    logic [3:0]      new_cnt;
    logic            cmp_en;
    logic            match_any;
    logic [1:0]      match_idx;
    logic [3:0]      code_nxt;
    logic [7:0]      hits_nxt;
    logic            last_shift;

    // Pattern table; writable in any state, the new value takes effect on
    // the compare following the write edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_tbl[0] <= 8'hF0;
            pat_tbl[1] <= 8'hCC;
            pat_tbl[2] <= 8'h33;
            pat_tbl[3] <= 8'h0F;
        end else if (cfg_we) begin
            pat_tbl[cfg_idx] <= cfg_pat;
        end
    end

    // Round-robin search: first set req bit starting just above the pointer,
    // wrapping, so the previous winner has the lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(rr_ptr) + off) % NREQ;
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IDW'(cand);
            end
        end
    end

    // byte_q is shifted left each SHIFT cycle, so its MSB is always the
    // next bit to feed into the window.
    always_comb begin
        new_window = {window[6:0], byte_q[7]};
        new_cnt    = (bit_cnt >= 4'd8) ? 4'd8 : bit_cnt + 4'd1;
        cmp_en     = (new_cnt == 4'd8);
        last_shift = (shift_k == 3'd7);
        match_any  = 1'b0;
        match_idx  = 2'd0;
        // Scanning downward leaves the lowest matching index as the winner.
        for (int i = 3; i >= 0; i--) begin
            if (new_window == pat_tbl[i]) begin
                match_any = 1'b1;
                match_idx = 2'(i);
            end
        end
        code_nxt = code_acc;
        hits_nxt = hit_cnt;
        if (cmp_en && match_any) begin
            code_nxt = 4'(match_idx) + 4'd1;
            hits_nxt = (hit_cnt == 8'hFF) ? 8'hFF : hit_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        byte_rdy   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                byte_rdy = 1'b1;
                if (byte_vld) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    next_state = last_q ? DONE : FETCH;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Frame datapath and registered result. The result registers are loaded
    // on the edge that enters DONE so they are stable during the strobe and
    // hold until the next frame completes. rr_ptr doubles as the id of the
    // frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            rr_ptr    <= IDW'(NREQ - 1);
            window    <= '0;
            bit_cnt   <= '0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            shift_k   <= '0;
            code_acc  <= '0;
            hit_cnt   <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_code  <= '0;
            res_hits  <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
                        rr_ptr   <= arb_idx;
                        window   <= '0;
                        bit_cnt  <= '0;
                        code_acc <= '0;
                        hit_cnt  <= '0;
                    end
                end
                FETCH: begin
                    if (byte_vld) begin
                        byte_q  <= byte_in;
                        last_q  <= byte_last;
                        shift_k <= '0;
                    end
                end
                SHIFT: begin
                    window   <= new_window;
                    bit_cnt  <= new_cnt;
                    byte_q   <= {byte_q[6:0], 1'b0};
                    shift_k  <= shift_k + 3'd1;
                    code_acc <= code_nxt;
                    hit_cnt  <= hits_nxt;
                    if (last_shift && last_q) begin
                        gnt       <= '0;
                        res_valid <= 1'b1;
                        res_id    <= rr_ptr;
                        res_code  <= code_nxt;
                        res_hits  <= hits_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb_seq_detect_scheduler
//
// Directed self-checking bench for seq_detect_scheduler. The bench acts as
// every requester: it raises req, answers byte_rdy with bytes from
// frame_bytes, and checks grant, result timing and result contents against
// hand-computed values.

module tb_seq_detect_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk;
    logic            rst;
    logic            cfg_we;
    logic [1:0]      cfg_idx;
    logic [7:0]      cfg_pat;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            byte_rdy;
    logic            byte_vld;
    logic [7:0]      byte_in;
    logic            byte_last;
    logic            res_valid;
    logic [IDW-1:0]  res_id;
    logic [3:0]      res_code;
    logic [7:0]      res_hits;

    int checks;
    int errors;

    logic [7:0] frame_bytes [64];

    seq_detect_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_pat   (cfg_pat),
        .req       (req),
        .gnt       (gnt),
        .byte_rdy  (byte_rdy),
        .byte_vld  (byte_vld),
        .byte_in   (byte_in),
        .byte_last (byte_last),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_code  (res_code),
        .res_hits  (res_hits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic writeTable(input logic [1:0] idx, input logic [7:0] pat);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_pat = pat;
        step();
        cfg_we  = 1'b0;
    endtask

    // Runs one frame of nbytes from frame_bytes. Cycle numbering: the edge
    // after req is raised is edge 0, so the cycle following it is cycle 1.
    // A nonzero abort_at asserts rst in that cycle and checks the abort.
    task automatic applyStimulus(input logic [NREQ-1:0] req_v, input int nbytes, input int stall,
                                 input bit hold_req, input int abort_at,
                                 output int res_cycle, output logic [NREQ-1:0] gnt_seen,
                                 output logic [IDW-1:0] r_id, output logic [3:0] r_code,
                                 output logic [7:0] r_hits);
        int  cycle;
        int  idx;
        int  stall_left;
        bit  accepted;
        bit  seen;
        res_cycle = -1;
        r_id      = '0;
        r_code    = '0;
        r_hits    = '0;
        req       = req_v;
        step();
        cycle     = 1;
        gnt_seen  = gnt;
        if (!hold_req) req = '0;
        idx        = 0;
        stall_left = stall;
        while (cycle < 1000) begin
            if (abort_at != 0 && cycle == abort_at) begin
                byte_vld = 1'b0;
                rst = 1'b1;
                #1;
                checkOutput("abort_gnt", 32'(gnt), 32'h0);
                checkOutput("abort_rdy", 32'(byte_rdy), 32'h0);
                checkOutput("abort_valid", 32'(res_valid), 32'h0);
                checkOutput("abort_code", 32'(res_code), 32'h0);
                checkOutput("abort_hits", 32'(res_hits), 32'h0);
                step();
                rst  = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 30; i++) begin
                    step();
                    if (res_valid) seen = 1'b1;
                end
                checkOutput("abort_no_result", 32'(seen), 32'h0);
                return;
            end
            if (res_valid) begin
                res_cycle = cycle;
                r_id      = res_id;
                r_code    = res_code;
                r_hits    = res_hits;
                byte_vld  = 1'b0;
                return;
            end
            byte_vld  = 1'b0;
            byte_last = 1'b0;
            if (byte_rdy && idx < nbytes) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    byte_vld  = 1'b1;
                    byte_in   = frame_bytes[idx];
                    byte_last = (idx == nbytes - 1);
                end
            end
            accepted = byte_rdy && byte_vld;
            step();
            cycle++;
            if (accepted) idx++;
        end
        byte_vld = 1'b0;
        checkOutput("timeout", 32'h0, 32'h1);
    endtask

    int              rc;
    logic [NREQ-1:0] g;
    logic [IDW-1:0]  rid;
    logic [3:0]      rcode;
    logic [7:0]      rhits;

    initial begin
        checks    = 0;
        errors    = 0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_pat   = '0;
        req       = '0;
        byte_vld  = 1'b0;
        byte_in   = '0;
        byte_last = 1'b0;
        applyReset();

        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_rdy", 32'(byte_rdy), 32'h0);
        checkOutput("rst_valid", 32'(res_valid), 32'h0);
        checkOutput("rst_id", 32'(res_id), 32'h0);
        checkOutput("rst_code", 32'(res_code), 32'h0);
        checkOutput("rst_hits", 32'(res_hits), 32'h0);

        // Single 0xF0 byte on req0
        frame_bytes[0] = 8'hF0;
        applyStimulus(4'b0001, 1, 0, 1'b0, 0, rc, g, rid, rcode, rhits);
        checkOutput("pat_gnt", 32'(g), 32'h1);
        checkOutput("pat_cycle", 32'(rc), 32'd10);
        checkOutput("pat_id", 32'(rid), 32'd0);
        checkOutput("pat_code", 32'(rcode), 32'd1);
        checkOutput("pat_hits", 32'(rhits), 32'd1);
        step();
        checkOutput("pat_strobe_one", 32'(res_valid), 32'h0);
        checkOutput("pat_hold_hits", 32'(res_hits), 32'd1);
        checkOutput("pat_gnt_clear", 32'(gnt), 32'h0);

        // Overlapping matches across two 0xCC bytes on req1
        frame_bytes[0] = 8'hCC;
        frame_bytes[1] = 8'hCC;
        applyStimulus(4'b0010, 2, 0, 1'b0, 0, rc, g, rid, rcode, rhits);
        checkOutput("ovl_gnt", 32'(g), 32'h2);
        checkOutput("ovl_cycle", 32'(rc), 32'd19);
        checkOutput("ovl_id", 32'(rid), 32'd1);
        checkOutput("ovl_code", 32'(rcode), 32'd2);
        checkOutput("ovl_hits", 32'(rhits), 32'd5);
        step();

        // Round robin with req0 and req2 held high
        applyReset();
        frame_bytes[0] = 8'h00;
        applyStimulus(4'b0101, 1, 0, 1'b1, 0, rc, g, rid, rcode, rhits);
        checkOutput("rr1_gnt", 32'(g), 32'h1);
        checkOutput("rr1_id", 32'(rid), 32'd0);
        checkOutput("rr1_code", 32'(rcode), 32'd0);
        checkOutput("rr1_hits", 32'(rhits), 32'd0);
        step();
        applyStimulus(4'b0101, 1, 0, 1'b1, 0, rc, g, rid, rcode, rhits);
        checkOutput("rr2_gnt", 32'(g), 32'h4);
        checkOutput("rr2_id", 32'(rid), 32'd2);
        checkOutput("rr2_code", 32'(rcode), 32'd0);
        checkOutput("rr2_hits", 32'(rhits), 32'd0);
        step();
        applyStimulus(4'b0101, 1, 0, 1'b1, 0, rc, g, rid, rcode, rhits);
        checkOutput("rr3_gnt", 32'(g), 32'h1);
        checkOutput("rr3_id", 32'(rid), 32'd0);
        req = '0;
        step();

        // Three stalled FETCH cycles on a 0x0F frame
        applyReset();
        frame_bytes[0] = 8'h0F;
        applyStimulus(4'b0001, 1, 3, 1'b0, 0, rc, g, rid, rcode, rhits);
        checkOutput("stall_cycle", 32'(rc), 32'd13);
        checkOutput("stall_code", 32'(rcode), 32'd4);
        checkOutput("stall_hits", 32'(rhits), 32'd1);
        step();

        // Table write then matching frame
        applyReset();
        writeTable(2'd3, 8'hAA);
        frame_bytes[0] = 8'hAA;
        applyStimulus(4'b0001, 1, 0, 1'b0, 0, rc, g, rid, rcode, rhits);
        checkOutput("wr_code", 32'(rcode), 32'd4);
        checkOutput("wr_hits", 32'(rhits), 32'd1);
        step();

        // Hit counter saturation: 40 zero bytes against entry0 = 0x00
        writeTable(2'd0, 8'h00);
        for (int i = 0; i < 40; i++) frame_bytes[i] = 8'h00;
        applyStimulus(4'b0001, 40, 0, 1'b0, 0, rc, g, rid, rcode, rhits);
        checkOutput("sat_cycle", 32'(rc), 32'd361);
        checkOutput("sat_code", 32'(rcode), 32'd1);
        checkOutput("sat_hits", 32'(rhits), 32'd255);
        step();

        // Reset during the second byte's SHIFT phase
        frame_bytes[0] = 8'hF0;
        frame_bytes[1] = 8'hF0;
        applyStimulus(4'b0001, 2, 0, 1'b0, 13, rc, g, rid, rcode, rhits);

        // Fresh frame after the abort; table is back to its reset contents
        frame_bytes[0] = 8'hF0;
        applyStimulus(4'b0001, 1, 0, 1'b0, 0, rc, g, rid, rcode, rhits);
        checkOutput("post_gnt", 32'(g), 32'h1);
        checkOutput("post_cycle", 32'(rc), 32'd10);
        checkOutput("post_id", 32'(rid), 32'd0);
        checkOutput("post_code", 32'(rcode), 32'd1);
        checkOutput("post_hits", 32'(rhits), 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Shares one serial 8-bit pattern-detect window between NREQ byte-stream requesters.
- Grants requesters round-robin, one frame at a time, and fetches the granted requester's bytes over a valid/ready handshake.
- Serializes each byte MSB-first, one bit per clock, into the window and compares against a 4-entry programmable pattern table.
- Emits one result per frame: requester id, last match code and saturating hit count.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of res_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  pattern-table write strobe.
- cfg_idx  in  2  table entry to write.
- cfg_pat  in  8  pattern value to write.
- req  in  NREQ  per-requester frame request, level.
- gnt  out  NREQ  one-hot grant; held for the whole frame.
- byte_rdy  out  1  scheduler ready for the next byte from the granted requester.
- byte_vld  in  1  granted requester's byte is valid.
- byte_in  in  8  byte data.
- byte_last  in  1  qualifies byte_in as the final byte of the frame.
- res_valid  out  1  one-cycle result strobe; no backpressure.
- res_id  out  IDW  index of the requester the result belongs to.
- res_code  out  4  last match code in the frame: 1..4 = table entry 0..3, 0 = none.
- res_hits  out  8  total matches in the frame, saturating at 255.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, window 0, bit count 0, RR pointer NREQ-1.
  - Table resets to: entry0 0xF0, entry1 0xCC, entry2 0x33, entry3 0x0F.
- Reset mid-frame aborts the frame; no result is emitted.
- Table write: when cfg_we=1, entry cfg_idx takes cfg_pat at the clock edge. Legal in any state; the new value is used from the next compare.
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - If req != 0, pick the first set bit searching upward from RR pointer+1, wrapping.
  - Register the one-hot gnt, update RR pointer to the winner.
  - Clear window, bit count, res_code accumulator and hit counter; go to FETCH.
- FETCH:
  - byte_rdy=1. On byte_vld=1, capture byte_in and byte_last, then go to SHIFT.
  - Otherwise stay in FETCH indefinitely; stalls are allowed.
- SHIFT: exactly 8 cycles, byte_rdy=0. Each cycle:
  - window <= {window[6:0], byte[7-k]}, where k = 0..7.
  - Bit count increments, saturating at 8.
  - Compare is enabled once the updated bit count is >= 8, i.e. from the 8th bit of the frame onward; comparison uses the updated window.
  - On a match, the lowest matching table index wins, the code accumulator takes index+1, and hits increments with saturation at 255.
- After the 8th SHIFT cycle: go to DONE if the captured last flag is 1, else go to FETCH.
- DONE:
  - res_valid=1 for one cycle, with res_id, res_code and res_hits stable.
  - gnt clears in the same cycle; go to IDLE.
  - res_id, res_code and res_hits hold their values until the next DONE.
- Deasserting req mid-frame is ignored; only byte_last ends a frame.
- Other req lines never preempt the current frame.
- Latency with no stalls: req sampled in IDLE at edge 0 gives res_valid in cycle 1+9K for a K-byte frame. Each stalled FETCH cycle adds 1.
- Back-to-back frames: at least one IDLE cycle separates DONE and the next grant.

Test Plan:
- Pattern match: reset; req[0]=1 with one byte 0xF0, last=1, no stall -> gnt=0001 at cycle 1; res_valid at cycle 10 with res_id=0, res_code=1, res_hits=1.
- Overlapping matches: req[1] frame 0xCC,0xCC (last on 2nd) -> matches after bits 8,10,12,14,16 (CC,33,CC,33,CC); res_code=2, res_hits=5, res_valid at cycle 19.
- Round-robin order: req=0101 held high, each frame a single byte 0x00 -> grants in order req0, req2, req0; each result has res_code=0, res_hits=0.
- Stall: byte_vld low for 3 FETCH cycles on a 1-byte 0x0F frame -> res_valid at cycle 13, res_code=4, res_hits=1.
- Table write and saturation:
  - Write idx3=0xAA, then frame 0xAA -> res_code=4, res_hits=1.
  - Write idx0=0x00, then 40 bytes of 0x00 -> res_code=1, res_hits=255.
- Reset mid-SHIFT: assert rst during the 2nd byte -> outputs 0 immediately; no res_valid. After release, a new 0xF0 frame gives the expected result from req0.
